// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes, FSM state types and byte-strobe merge helper
//
// Contents:
//   AXI_OK, AXI_SLVERR : response encodings
//   w_state_t          : write channel FSM states
//   r_state_t          : read channel FSM states
//   strb_merge()       : byte-lane merge of new data into an old word under a strobe
package axi_lite_pkg;

    localparam logic [1:0] AXI_OK     = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_DATA,
        W_ADDR,
        W_COMMIT,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_VALID
    } r_state_t;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_data,
        input logic [31:0] new_data,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = strb[k] ? new_data[8*k +: 8] : old_data[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_cfg_regfile.sv
// rtl/axil_cfg_regfile.sv - parametrised AXI4-Lite configuration/status register file
//
// Ports:
//   s_axi_lite_aclk        sole clock
//   axi_resetn             synchronous active-low reset
//   s_axi_lite_aw*         write address channel
//   s_axi_lite_w*          write data channel (32-bit data, 4-bit byte strobe)
//   s_axi_lite_b*          write response channel
//   s_axi_lite_ar*         read address channel
//   s_axi_lite_r*          read data channel
//   cfg_out                all registers in parallel, register i at [32*i +: 32]; RO slots drive 0
//   status_in              read values for read-only registers, same packing as cfg_out
//   wr_pulse               one-cycle strobe per successful write, bit i for register i
module axil_cfg_regfile
    import axi_lite_pkg::*;
#(
    parameter int                       NUM_REGS            = 8,
    parameter int                       AXI_LITE_ADDR_WIDTH = 8,
    parameter logic [NUM_REGS-1:0]      RO_MASK             = '0,
    parameter logic [NUM_REGS*32-1:0]   RESET_VALUE         = '0
) (
    input  logic                            s_axi_lite_aclk,
    input  logic                            axi_resetn,

    input  logic [AXI_LITE_ADDR_WIDTH-1:0]  s_axi_lite_awaddr,
    input  logic                            s_axi_lite_awvalid,
    output logic                            s_axi_lite_awready,

    input  logic [31:0]                     s_axi_lite_wdata,
    input  logic [3:0]                      s_axi_lite_wstrb,
    input  logic                            s_axi_lite_wvalid,
    output logic                            s_axi_lite_wready,

    output logic [1:0]                      s_axi_lite_bresp,
    output logic                            s_axi_lite_bvalid,
    input  logic                            s_axi_lite_bready,

    input  logic [AXI_LITE_ADDR_WIDTH-1:0]  s_axi_lite_araddr,
    input  logic                            s_axi_lite_arvalid,
    output logic                            s_axi_lite_arready,

    output logic [31:0]                     s_axi_lite_rdata,
    output logic [1:0]                      s_axi_lite_rresp,
    output logic                            s_axi_lite_rvalid,
    input  logic                            s_axi_lite_rready,

    output logic [NUM_REGS*32-1:0]          cfg_out,
    input  logic [NUM_REGS*32-1:0]          status_in,
    output logic [NUM_REGS-1:0]             wr_pulse
);

    localparam int IW = AXI_LITE_ADDR_WIDTH - 2;

    logic [31:0]         regs [NUM_REGS];

    w_state_t            w_state;
    logic [IW-1:0]       w_idx;
    logic [31:0]         w_data;
    logic [3:0]          w_strb;
    logic [1:0]          bresp_q;
    logic [NUM_REGS-1:0] pulse_q;

    r_state_t            r_state;
    logic [IW-1:0]       r_idx;
    logic [31:0]         rdata_q;
    logic [1:0]          rresp_q;

    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;

    logic [NUM_REGS-1:0] w_sel;
    logic                w_ok;
    logic [31:0]         r_mux;
    logic                r_ok;

    // Byte-offset address bits carry no information for 32-bit registers.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

    // Channel flags are decoded straight from state so they drop during reset
    // and are already high in the first cycle after release.
    assign s_axi_lite_awready = axi_resetn && (w_state == W_IDLE || w_state == W_ADDR);
    assign s_axi_lite_wready  = axi_resetn && (w_state == W_IDLE || w_state == W_DATA);
    assign s_axi_lite_bvalid  = axi_resetn && (w_state == W_RESP);
    assign s_axi_lite_bresp   = bresp_q;
    assign s_axi_lite_arready = axi_resetn && (r_state == R_IDLE);
    assign s_axi_lite_rvalid  = axi_resetn && (r_state == R_VALID);
    assign s_axi_lite_rdata   = rdata_q;
    assign s_axi_lite_rresp   = rresp_q;
    assign wr_pulse           = pulse_q & {NUM_REGS{axi_resetn}};

    assign aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
    assign w_hs  = s_axi_lite_wvalid  && s_axi_lite_wready;
    assign ar_hs = s_axi_lite_arvalid && s_axi_lite_arready;

    // Decode compares the full index field, so aliasing above NUM_REGS is
    // impossible; an index that matches no slot simply selects nothing.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(w_idx) == i && !RO_MASK[i]) begin
                w_sel[i] = 1'b1;
            end
        end
    end
    assign w_ok = |w_sel;

    always_comb begin
        r_mux = '0;
        r_ok  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(r_idx) == i) begin
                r_ok  = 1'b1;
                r_mux = RO_MASK[i] ? status_in[32*i +: 32] : regs[i];
            end
        end
    end

    always_comb begin
        cfg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cfg_out[32*i +: 32] = RO_MASK[i] ? 32'h0 : regs[i];
        end
    end

    // Write FSM and register storage.
    always_ff @(posedge s_axi_lite_aclk) begin
        if (!axi_resetn) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp_q <= AXI_OK;
            pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RO_MASK[i] ? 32'h0 : RESET_VALUE[32*i +: 32];
            end
        end else begin
            pulse_q <= '0;
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_idx <= s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:2];
                    end
                    if (w_hs) begin
                        w_data <= s_axi_lite_wdata;
                        w_strb <= s_axi_lite_wstrb;
                    end
                    if (aw_hs && w_hs) begin
                        w_state <= W_COMMIT;
                    end else if (aw_hs) begin
                        w_state <= W_DATA;
                    end else if (w_hs) begin
                        w_state <= W_ADDR;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_data  <= s_axi_lite_wdata;
                        w_strb  <= s_axi_lite_wstrb;
                        w_state <= W_COMMIT;
                    end
                end
                W_ADDR: begin
                    if (aw_hs) begin
                        w_idx   <= s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:2];
                        w_state <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (w_sel[i]) begin
                            regs[i] <= strb_merge(regs[i], w_data, w_strb);
                        end
                    end
                    // Pulse fires even for an all-zero strobe: the write was accepted.
                    pulse_q <= w_sel;
                    bresp_q <= w_ok ? AXI_OK : AXI_SLVERR;
                    w_state <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_lite_bready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM. The fetch samples regs before any same-cycle commit lands,
    // so a colliding read returns the pre-write value.
    always_ff @(posedge s_axi_lite_aclk) begin
        if (!axi_resetn) begin
            r_state <= R_IDLE;
            r_idx   <= '0;
            rdata_q <= '0;
            rresp_q <= AXI_OK;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_idx   <= s_axi_lite_araddr[AXI_LITE_ADDR_WIDTH-1:2];
                        r_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rdata_q <= r_ok ? r_mux : 32'h0;
                    rresp_q <= r_ok ? AXI_OK : AXI_SLVERR;
                    r_state <= R_VALID;
                end
                R_VALID: begin
                    if (s_axi_lite_rready) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cfg_regfile.sv
// tb/tb_axil_cfg_regfile.sv - self-checking bench for axil_cfg_regfile
module tb_axil_cfg_regfile;

    localparam int NR = 8;
    localparam logic [NR*32-1:0] RV = {
        32'h77777777, 32'h66000066, 32'h00000000, 32'h44444444,
        32'hCAFE0003, 32'h00000000, 32'h0093EA1C, 32'h0000A000
    };

    logic             clk = 1'b0;
    logic             axi_resetn = 1'b0;
    logic [7:0]       awaddr = '0;
    logic             awvalid = 1'b0;
    logic             awready;
    logic [31:0]      wdata = '0;
    logic [3:0]       wstrb = '0;
    logic             wvalid = 1'b0;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready = 1'b0;
    logic [7:0]       araddr = '0;
    logic             arvalid = 1'b0;
    logic             arready;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready = 1'b0;
    logic [NR*32-1:0] cfg_out;
    logic [NR*32-1:0] status_in;
    logic [NR-1:0]    wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_regs [NR];

    always #5 clk = ~clk;

    axil_cfg_regfile #(
        .NUM_REGS(NR),
        .AXI_LITE_ADDR_WIDTH(8),
        .RO_MASK(8'h80),
        .RESET_VALUE(RV)
    ) dut (
        .s_axi_lite_aclk(clk),
        .axi_resetn(axi_resetn),
        .s_axi_lite_awaddr(awaddr),
        .s_axi_lite_awvalid(awvalid),
        .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata),
        .s_axi_lite_wstrb(wstrb),
        .s_axi_lite_wvalid(wvalid),
        .s_axi_lite_wready(wready),
        .s_axi_lite_bresp(bresp),
        .s_axi_lite_bvalid(bvalid),
        .s_axi_lite_bready(bready),
        .s_axi_lite_araddr(araddr),
        .s_axi_lite_arvalid(arvalid),
        .s_axi_lite_arready(arready),
        .s_axi_lite_rdata(rdata),
        .s_axi_lite_rresp(rresp),
        .s_axi_lite_rvalid(rvalid),
        .s_axi_lite_rready(rready),
        .cfg_out(cfg_out),
        .status_in(status_in),
        .wr_pulse(wr_pulse)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp;
        logic [7:0]  pulse;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cfg(input string name, input logic [NR*32-1:0] snap);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("%s cfg[%0d]", name, i), snap[32*i +: 32], exp_regs[i]);
        end
    endtask

    task automatic load_reset_model();
        logic [NR*32-1:0] rv_v;
        rv_v = RV;
        for (int i = 0; i < NR; i++) exp_regs[i] = rv_v[32*i +: 32];
        exp_regs[7] = 32'h0;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [7:0] pulse, output int lat,
                             output int pulse_cycles, output logic [NR*32-1:0] snap,
                             output logic bvalid_after);
        int n;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("write accept timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        lat = 0; pulse = '0; pulse_cycles = 0; resp = 2'b11; snap = '0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (wr_pulse != '0) pulse_cycles++;
            if (bvalid) begin
                resp = bresp; pulse = wr_pulse; snap = cfg_out;
                break;
            end
        end
        @(negedge clk);
        if (wr_pulse != '0) pulse_cycles++;
        bvalid_after = bvalid;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int lat, output logic arready_after);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("read accept timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        lat = 0; d = '0; resp = 2'b11;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (rvalid) begin
                d = rdata; resp = rresp;
                break;
            end
        end
        @(negedge clk);
        arready_after = arready;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]       resp;
        logic [7:0]       pulse;
        logic [31:0]      d;
        logic [NR*32-1:0] snap;
        logic             flag;
        int               lat;
        int               pc;
        int               n;

        status_in = '0;
        status_in[255:224] = 32'h12345678;
        status_in[63:32]   = 32'hBADBAD00;   // RW slot: must be ignored
        load_reset_model();

        tbl[0]  = '{1'b0, 8'h04, 32'h0,        4'h0,    2'b00, 32'h0093EA1C, 8'h00};
        tbl[1]  = '{1'b1, 8'h08, 32'hDEADBEEF, 4'b0101, 2'b00, 32'h00AD00EF, 8'h04};
        tbl[2]  = '{1'b0, 8'h08, 32'h0,        4'h0,    2'b00, 32'h00AD00EF, 8'h00};
        tbl[3]  = '{1'b1, 8'h08, 32'h11223344, 4'b1010, 2'b00, 32'h11AD33EF, 8'h04};
        tbl[4]  = '{1'b1, 8'h0C, 32'hFFFFFFFF, 4'b0000, 2'b00, 32'hCAFE0003, 8'h08};
        tbl[5]  = '{1'b1, 8'h20, 32'h55555555, 4'b1111, 2'b10, 32'h0,        8'h00};
        tbl[6]  = '{1'b0, 8'h20, 32'h0,        4'h0,    2'b10, 32'h0,        8'h00};
        tbl[7]  = '{1'b0, 8'h1C, 32'h0,        4'h0,    2'b00, 32'h12345678, 8'h00};
        tbl[8]  = '{1'b1, 8'h1C, 32'h99999999, 4'b1111, 2'b10, 32'h0,        8'h00};
        tbl[9]  = '{1'b0, 8'hFC, 32'h0,        4'h0,    2'b10, 32'h0,        8'h00};
        tbl[10] = '{1'b1, 8'h17, 32'hA5A5A5A5, 4'b1111, 2'b00, 32'hA5A5A5A5, 8'h20};
        tbl[11] = '{1'b0, 8'h15, 32'h0,        4'h0,    2'b00, 32'hA5A5A5A5, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset awready", 32'(awready), 32'd0);
        chk("reset wready",  32'(wready),  32'd0);
        chk("reset arready", 32'(arready), 32'd0);
        chk("reset bvalid",  32'(bvalid),  32'd0);
        chk("reset rvalid",  32'(rvalid),  32'd0);
        chk("reset wr_pulse", 32'(wr_pulse), 32'd0);
        chk("reset rdata",   rdata, 32'd0);
        chk("reset rresp",   32'(rresp), 32'd0);
        chk("reset bresp",   32'(bresp), 32'd0);
        axi_resetn = 1'b1;
        #1;
        chk("release awready", 32'(awready), 32'd1);
        chk("release wready",  32'(wready),  32'd1);
        chk("release arready", 32'(arready), 32'd1);
        chk_cfg("after reset", cfg_out);

        // Table-driven single transactions
        for (int r = 0; r < 12; r++) begin
            if (tbl[r].wr) begin
                if (tbl[r].resp == 2'b00) exp_regs[tbl[r].addr[4:2]] = tbl[r].exp;
                axi_write(tbl[r].addr, tbl[r].data, tbl[r].strb, resp, pulse, lat, pc, snap, flag);
                chk($sformatf("row%0d bresp", r), 32'(resp), 32'(tbl[r].resp));
                chk($sformatf("row%0d wr_pulse", r), 32'(pulse), 32'(tbl[r].pulse));
                chk($sformatf("row%0d b latency", r), lat, 32'd2);
                chk($sformatf("row%0d pulse cycles", r), pc, (tbl[r].pulse != 8'h00) ? 32'd1 : 32'd0);
                chk($sformatf("row%0d bvalid after", r), 32'(flag), 32'd0);
                chk_cfg($sformatf("row%0d", r), snap);
            end else begin
                axi_read(tbl[r].addr, d, resp, lat, flag);
                chk($sformatf("row%0d rdata", r), d, tbl[r].exp);
                chk($sformatf("row%0d rresp", r), 32'(resp), 32'(tbl[r].resp));
                chk($sformatf("row%0d r latency", r), lat, 32'd2);
                chk($sformatf("row%0d arready after", r), 32'(flag), 32'd1);
            end
        end

        // W first, AW five cycles later, bready held low for four cycles
        @(negedge clk);
        wdata = 32'h76543210; wstrb = 4'b1100; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk);
        #1 wvalid = 1'b0;
        repeat (5) @(negedge clk);
        chk("split awready in W_ADDR", 32'(awready), 32'd1);
        chk("split wready in W_ADDR",  32'(wready),  32'd0);
        chk("split bvalid early",      32'(bvalid),  32'd0);
        awaddr = 8'h00; awvalid = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (bvalid) break;
        end
        chk("split b latency", lat, 32'd2);
        exp_regs[0] = 32'h7654A000;
        chk_cfg("split", cfg_out);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("split hold%0d bvalid", k), 32'(bvalid), 32'd1);
            chk($sformatf("split hold%0d bresp", k), 32'(bresp), 32'd0);
            chk($sformatf("split hold%0d wr_pulse", k), 32'(wr_pulse), 32'd0);
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("split bvalid after", 32'(bvalid), 32'd0);
        chk("split awready after", 32'(awready), 32'd1);

        // Read and write collide on reg 4: read must see the old value
        @(negedge clk);
        awaddr = 8'h10; awvalid = 1'b1; wdata = 32'hABCD1234; wstrb = 4'b1111; wvalid = 1'b1;
        araddr = 8'h10; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_regs[4] = 32'hABCD1234;
        chk("collide bvalid", 32'(bvalid), 32'd1);
        chk("collide rvalid", 32'(rvalid), 32'd1);
        chk("collide rdata old", rdata, 32'h44444444);
        chk("collide wr_pulse", 32'(wr_pulse), 32'h10);
        chk_cfg("collide", cfg_out);
        @(negedge clk);
        chk("collide bvalid after", 32'(bvalid), 32'd0);
        chk("collide rvalid after", 32'(rvalid), 32'd0);

        // Reset while write is in W_DATA and read is in R_VALID
        @(negedge clk);
        awaddr = 8'h18; awvalid = 1'b1; araddr = 8'h18; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk);
        #1 awvalid = 1'b0; arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("pre-reset rvalid", 32'(rvalid), 32'd1);
        chk("pre-reset W_DATA wready", 32'(wready), 32'd1);
        chk("pre-reset W_DATA awready", 32'(awready), 32'd0);
        axi_resetn = 1'b0;
        @(negedge clk);
        chk("mid reset rvalid", 32'(rvalid), 32'd0);
        chk("mid reset bvalid", 32'(bvalid), 32'd0);
        chk("mid reset wready", 32'(wready), 32'd0);
        chk("mid reset arready", 32'(arready), 32'd0);
        @(negedge clk);
        axi_resetn = 1'b1;
        rready = 1'b1;
        #1;
        chk("post reset awready", 32'(awready), 32'd1);
        chk("post reset wready",  32'(wready),  32'd1);
        chk("post reset arready", 32'(arready), 32'd1);
        chk("post reset rdata",   rdata, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post reset bvalid%0d", k), 32'(bvalid), 32'd0);
            chk($sformatf("post reset rvalid%0d", k), 32'(rvalid), 32'd0);
        end
        load_reset_model();
        chk_cfg("post reset", cfg_out);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
